i2s_dac_tx: RTL and testbench

//  Output stage after the voice datapath. Takes the finished 32-bit mixed TONE word once per audio

---
 rtl/i2s_dac_tx.sv | 179 +++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// I2S DAC output stage: saturating 32->16 bit scaling, small sample FIFO, mono sample sent on both channels.
// Build option UNDERRUN_HOLD_EN: on underrun repeat the last popped word instead of sending silence.

module i2s_dac_tx #(
    parameter int BCLK_HALF  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT      = 12
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [31:0]                 SAMPLE_IN,
    input  logic                        SAMPLE_VLD,
    input  logic                        CLR_FLAGS,
    output logic                        FRAME_REQ,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        OVERFLOW,
    output logic                        UNDERRUN,
    output logic                        BCLK,
    output logic                        LRCLK,
    output logic                        DACDAT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(BCLK_HALF + 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(BCLK_HALF - 1);
    localparam logic [DW-1:0] DIV_ZERO    = DW'(0);
    localparam logic [PW:0]   LEVEL_FULL  = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   LEVEL_EMPTY = (PW+1)'(0);
    localparam logic [PW:0]   LEVEL_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ZERO    = PW'(0);
    localparam logic [PW-1:0] PTR_ONE     = PW'(1);
    localparam logic [5:0]    BIT_LAST    = 6'd63;

    // Gain select followed by clamping to the signed 16-bit range.
    function automatic logic [15:0] scale_sample(input logic [31:0] raw);
        logic signed [31:0] s;
        s = $signed(raw) >>> SHIFT;
        if (s > 32'sd32767) begin
            return 16'h7FFF;
        end else if (s < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return s[15:0];
        end
    endfunction

    logic [DW-1:0] div_cnt_r;
    logic          bclk_r;
    logic [5:0]    bit_cnt_r;
    logic          lrclk_r;
    logic          dacdat_r;
    logic          frame_req_r;
    logic          overflow_r;
    logic          underrun_r;
    logic [PW:0]   level_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [15:0]   mem_r [FIFO_DEPTH];
    logic [15:0]   word_r;

    logic          fall_s;
    logic [5:0]    bit_nxt_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic          und_set_s;
    logic          ovf_set_s;
    logic [3:0]    slot_idx_s;
    logic          slot_bit_s;

    assign fall_s    = bclk_r & (div_cnt_r == DIV_LAST);
    assign bit_nxt_s = bit_cnt_r + 6'd1;
    assign pop_s     = fall_s & (bit_cnt_r == BIT_LAST);
    assign empty_s   = (level_r == LEVEL_EMPTY);
    assign full_s    = (level_r == LEVEL_FULL);
    assign pop_ok_s  = pop_s & ~empty_s;
    assign und_set_s = pop_s & empty_s;
    // A full FIFO can still accept a push when a pop frees the head slot in the same cycle.
    assign push_ok_s = SAMPLE_VLD & (~full_s | pop_s);
    assign ovf_set_s = SAMPLE_VLD & full_s & ~pop_s;

    // Slot map: both channel halves carry the word MSB first, one BCLK after the LRCLK edge.
    always_comb begin
        slot_idx_s = 4'(5'd16 - bit_nxt_s[4:0]);
        if ((bit_nxt_s[4:0] != 5'd0) && (bit_nxt_s[4:0] <= 5'd16)) begin
            slot_bit_s = word_r[slot_idx_s];
        end else begin
            slot_bit_s = 1'b0;
        end
    end

    // Bit clock divider, frame bit counter and serial outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt_r   <= DIV_ZERO;
            bclk_r      <= 1'b0;
            bit_cnt_r   <= BIT_LAST;
            lrclk_r     <= 1'b1;
            dacdat_r    <= 1'b0;
            frame_req_r <= 1'b0;
        end else begin
            frame_req_r <= pop_s;
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= DIV_ZERO;
                bclk_r    <= ~bclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
            if (fall_s) begin
                bit_cnt_r <= bit_nxt_s;
                lrclk_r   <= bit_nxt_s[5];
                dacdat_r  <= slot_bit_s;
            end
        end
    end

    // Sample FIFO and output word register; pop always sees the pre-cycle FIFO state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            level_r  <= LEVEL_EMPTY;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            word_r   <= 16'h0000;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= scale_sample(SAMPLE_IN);
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                word_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else if (und_set_s) begin
`ifdef UNDERRUN_HOLD_EN
                word_r <= word_r;
`else
                word_r <= 16'h0000;
`endif
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky status flags; a set event in the same cycle beats the clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (CLR_FLAGS) begin
                overflow_r <= 1'b0;
            end
            if (und_set_s) begin
                underrun_r <= 1'b1;
            end else if (CLR_FLAGS) begin
                underrun_r <= 1'b0;
            end
        end
    end

    assign FRAME_REQ  = frame_req_r;
    assign FIFO_LEVEL = level_r;
    assign OVERFLOW   = overflow_r;
    assign UNDERRUN   = underrun_r;
    assign BCLK       = bclk_r;
    assign LRCLK      = lrclk_r;
    assign DACDAT     = dacdat_r;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: queue-based reference model, frames decoded from the serial pins at BCLK rising.
// Honours UNDERRUN_HOLD_EN the same way as the design build.

module tb_i2s_dac_tx;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] SAMPLE_IN = 32'h0;
    logic        SAMPLE_VLD = 1'b0;
    logic        CLR_FLAGS = 1'b0;
    logic        FRAME_REQ;
    logic [2:0]  FIFO_LEVEL;
    logic        OVERFLOW;
    logic        UNDERRUN;
    logic        BCLK;
    logic        LRCLK;
    logic        DACDAT;

    i2s_dac_tx dut (
        .CLK(CLK), .RESET(RESET), .SAMPLE_IN(SAMPLE_IN), .SAMPLE_VLD(SAMPLE_VLD),
        .CLR_FLAGS(CLR_FLAGS), .FRAME_REQ(FRAME_REQ), .FIFO_LEVEL(FIFO_LEVEL),
        .OVERFLOW(OVERFLOW), .UNDERRUN(UNDERRUN), .BCLK(BCLK), .LRCLK(LRCLK), .DACDAT(DACDAT)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;
    localparam int POP_TIMEOUT = 1100;

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] exp_word;
    logic        m_ovf;
    logic        m_und;

    // Push schedule for one captured frame, indexed by CLK cycle after the pop
    logic        sched_v [1024];
    logic [31:0] sched_w [1024];

    function automatic logic [15:0] ref_scale(input logic [31:0] x);
        longint v;
        longint q;
        v = $signed(x);
        if (v >= 0) q = v / 4096;
        else        q = -((-v + 4095) / 4096);
        if (q > 32767)       return 16'h7FFF;
        else if (q < -32768) return 16'h8000;
        else                 return q[15:0];
    endfunction

    function automatic logic [63:0] frame_bits(input logic [15:0] w);
        logic [63:0] b;
        b = 64'h0;
        for (int i = 0; i < 64; i++) begin
            if (i >= 1 && i <= 16)       b[i] = w[16 - i];
            else if (i >= 33 && i <= 48) b[i] = w[48 - i];
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom_range(0, 32'h0FFF_FFFF) - 32'h0800_0000;
            2:       return 32'h07FF_F000 + $urandom_range(0, 8191) - 32'd4096;
            default: return 32'hF800_0000 + $urandom_range(0, 8191) - 32'd4096;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_word = 16'h0000;
        m_ovf = 1'b0;
        m_und = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            sched_v[i] = 1'b0;
            sched_w[i] = 32'h0;
        end
    endtask

    task automatic model_pop();
        if (mq.size() > 0) begin
            exp_word = mq.pop_front();
        end else begin
            m_und = 1'b1;
`ifndef UNDERRUN_HOLD_EN
            exp_word = 16'h0000;
`endif
        end
    endtask

    task automatic model_push(input logic [31:0] w);
        if (mq.size() < 4) mq.push_back(ref_scale(w));
        else               m_ovf = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RESET = 1'b1;
        SAMPLE_VLD = 1'b0;
        CLR_FLAGS = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        model_clear();
    endtask

    task automatic push_word(input logic [31:0] w);
        SAMPLE_IN = w;
        SAMPLE_VLD = 1'b1;
        @(negedge CLK);
        SAMPLE_VLD = 1'b0;
        model_push(w);
    endtask

    task automatic wait_pop(output int n);
        n = 0;
        while (FRAME_REQ !== 1'b1 && n < POP_TIMEOUT) begin
            @(negedge CLK);
            n++;
        end
        if (n < POP_TIMEOUT) model_pop();
    endtask

    // Runs one full frame starting at a FRAME_REQ cycle and ends on the next one.
    task automatic capture_frame(output logic [63:0] bits, output logic [63:0] lr, output int frq_n);
        logic prev;
        int   nb;
        bits = 64'h0;
        lr = 64'h0;
        frq_n = 0;
        nb = 0;
        prev = BCLK;
        for (int j = 0; j < 1024; j++) begin
            SAMPLE_VLD = sched_v[j];
            SAMPLE_IN = sched_w[j];
            @(negedge CLK);
            if (sched_v[j] && j != 1023) model_push(sched_w[j]);
            if (prev === 1'b0 && BCLK === 1'b1 && nb < 64) begin
                bits[nb] = DACDAT;
                lr[nb] = LRCLK;
                nb++;
            end
            prev = BCLK;
            if (FRAME_REQ === 1'b1) frq_n++;
        end
        SAMPLE_VLD = 1'b0;
        model_pop();
        if (sched_v[1023]) model_push(sched_w[1023]);
        for (int i = 0; i < 1024; i++) sched_v[i] = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int frq_n;
        logic [63:0] bits, lr;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        total_cnt++;
        if ({BCLK, LRCLK, DACDAT, FRAME_REQ, OVERFLOW, UNDERRUN, FIFO_LEVEL} !== 9'b0_1_0_0_0_0_000)
            $display("FAIL reset_values got=%b exp=%b",
                     {BCLK, LRCLK, DACDAT, FRAME_REQ, OVERFLOW, UNDERRUN, FIFO_LEVEL}, 9'b0_1_0_0_0_0_000);
        else pass_cnt++;
        RESET = 1'b0;
        model_clear();
        wait_pop(n);
        total_cnt++;
        if (n !== 16) $display("FAIL first_pop_latency got=%0d exp=16", n);
        else pass_cnt++;
        total_cnt++;
        if (UNDERRUN !== 1'b1) $display("FAIL underrun_first_pop got=%b exp=1", UNDERRUN);
        else pass_cnt++;
        capture_frame(bits, lr, frq_n);
        total_cnt++;
        if (frq_n !== 1 || FRAME_REQ !== 1'b1)
            $display("FAIL frame_period pulses=%0d frame_req=%b exp pulses=1 frame_req=1", frq_n, FRAME_REQ);
        else pass_cnt++;
        total_cnt++;
        if (bits !== 64'h0) $display("FAIL silent_dacdat got=%h exp=0", bits);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int n;
        int frq_n;
        logic [63:0] bits, lr;
        reset_dut();
        push_word(32'h0012_3000);
        wait_pop(n);
        total_cnt++;
        if (n >= POP_TIMEOUT || FIFO_LEVEL !== 3'd0)
            $display("FAIL basic_pop wait=%0d level=%0d exp level=0", n, FIFO_LEVEL);
        else pass_cnt++;
        capture_frame(bits, lr, frq_n);
        total_cnt++;
        if (bits !== frame_bits(16'h0123)) $display("FAIL basic_frame got=%h exp=%h", bits, frame_bits(16'h0123));
        else pass_cnt++;
        total_cnt++;
        if (lr !== LR_EXP) $display("FAIL basic_lrclk got=%h exp=%h", lr, LR_EXP);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int n;
        int frq_n;
        logic [63:0] bits, lr;
        logic [15:0] exp_list [3];
        exp_list = '{16'h7FFF, 16'h8000, 16'hFFFF};
        reset_dut();
        push_word(32'h7FFF_FFFF);
        push_word(32'h8000_0000);
        push_word(32'hFFFF_F000);
        wait_pop(n);
        for (int i = 0; i < 3; i++) begin
            capture_frame(bits, lr, frq_n);
            total_cnt++;
            if (bits !== frame_bits(exp_list[i]))
                $display("FAIL saturation_%0d got=%h exp=%h", i, bits, frame_bits(exp_list[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        int n;
        int frq_n;
        logic [63:0] bits, lr;
        logic [15:0] ew;
        reset_dut();
        for (int i = 0; i < 5; i++) push_word(rand_word());
        total_cnt++;
        if (FIFO_LEVEL !== 3'd4 || OVERFLOW !== 1'b1)
            $display("FAIL overflow_set level=%0d ovf=%b exp level=4 ovf=1", FIFO_LEVEL, OVERFLOW);
        else pass_cnt++;
        CLR_FLAGS = 1'b1;
        @(negedge CLK);
        CLR_FLAGS = 1'b0;
        m_ovf = 1'b0;
        m_und = 1'b0;
        total_cnt++;
        if (OVERFLOW !== 1'b0) $display("FAIL overflow_clear got=%b exp=0", OVERFLOW);
        else pass_cnt++;
        wait_pop(n);
        for (int i = 0; i < 5; i++) begin
            ew = exp_word;
            capture_frame(bits, lr, frq_n);
            total_cnt++;
            if (bits !== frame_bits(ew)) $display("FAIL overflow_frame_%0d got=%h exp=%h", i, bits, frame_bits(ew));
            else pass_cnt++;
        end
        total_cnt++;
        if (UNDERRUN !== 1'b1 || FIFO_LEVEL !== 3'd0)
            $display("FAIL overflow_drain und=%b level=%0d exp und=1 level=0", UNDERRUN, FIFO_LEVEL);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        int n;
        int frq_n;
        logic [63:0] bits, lr;
        logic [15:0] ew;
        logic [31:0] w2;
        reset_dut();
        push_word(rand_word());
        wait_pop(n);
        w2 = rand_word();
        sched_v[1023] = 1'b1;
        sched_w[1023] = w2;
        capture_frame(bits, lr, frq_n);
        total_cnt++;
        if (FRAME_REQ !== 1'b1 || UNDERRUN !== 1'b1 || FIFO_LEVEL !== 3'd1)
            $display("FAIL collision_state frq=%b und=%b level=%0d exp 1 1 1", FRAME_REQ, UNDERRUN, FIFO_LEVEL);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            ew = exp_word;
            capture_frame(bits, lr, frq_n);
            total_cnt++;
            if (bits !== frame_bits(ew)) $display("FAIL collision_frame_%0d got=%h exp=%h", i, bits, frame_bits(ew));
            else pass_cnt++;
        end
        total_cnt++;
        if (ew !== ref_scale(w2)) $display("FAIL collision_word_model got=%h exp=%h", ew, ref_scale(w2));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int n;
        int frq_n;
        logic [63:0] bits, lr;
        logic [15:0] ew;
        reset_dut();
        wait_pop(n);
        for (int f = 0; f < 10; f++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                int j;
                j = ($urandom_range(0, 5) == 0) ? 1023 : $urandom_range(0, 1022);
                sched_v[j] = 1'b1;
                sched_w[j] = rand_word();
            end
            ew = exp_word;
            capture_frame(bits, lr, frq_n);
            total_cnt++;
            if (bits !== frame_bits(ew) || lr !== LR_EXP || frq_n !== 1)
                $display("FAIL random_frame_%0d got=%h lr=%h exp=%h", f, bits, lr, frame_bits(ew));
            else pass_cnt++;
            total_cnt++;
            if (FIFO_LEVEL !== 3'(mq.size()) || OVERFLOW !== m_ovf || UNDERRUN !== m_und)
                $display("FAIL random_status_%0d got lvl=%0d ovf=%b und=%b exp lvl=%0d ovf=%b und=%b",
                         f, FIFO_LEVEL, OVERFLOW, UNDERRUN, mq.size(), m_ovf, m_und);
            else pass_cnt++;
        end
    endtask

    task automatic test_midreset();
        int n;
        reset_dut();
        for (int i = 0; i < 5; i++) push_word(rand_word());
        wait_pop(n);
        repeat (644) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if ({BCLK, LRCLK, DACDAT, FRAME_REQ, OVERFLOW, UNDERRUN, FIFO_LEVEL} !== 9'b0_1_0_0_0_0_000)
            $display("FAIL midreset_values got=%b exp=%b",
                     {BCLK, LRCLK, DACDAT, FRAME_REQ, OVERFLOW, UNDERRUN, FIFO_LEVEL}, 9'b0_1_0_0_0_0_000);
        else pass_cnt++;
        RESET = 1'b0;
        model_clear();
        wait_pop(n);
        total_cnt++;
        if (n !== 16) $display("FAIL midreset_first_pop got=%0d exp=16", n);
        else pass_cnt++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_collision();
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
